spi_reg_ctrl: RTL and testbench

//  Command sequencer behind the spi_slaver byte datapath. Frames the received byte stream
//  (cs low..high) into register transactions: first byte is a command, following bytes are

---
 rtl/spi_reg_ctrl_if.sv | 21 ++
 rtl/spi_reg_ctrl.sv | 151 +++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_ctrl_if.sv
// Register bus between the SPI command sequencer (master) and user register logic (slave).
// Strobes are single-cycle; read data is returned exactly one clock after bus_rd.
interface spi_reg_ctrl_if #(
  parameter int AW = 4
);
  logic [AW-1:0] bus_addr;
  logic          bus_wr;
  logic [7:0]    bus_wdata;
  logic          bus_rd;
  logic [7:0]    bus_rdata;

  modport master (
    output bus_addr, bus_wr, bus_wdata, bus_rd,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wr, bus_wdata, bus_rd,
    output bus_rdata
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// Frames the spi_slaver byte stream into register reads/writes with auto-incrementing address.
// Write strobe 1 clk after a byte; txd_data reloaded 3 clks after a read byte; no backpressure.
module spi_reg_ctrl #(
  parameter int         AW       = 4,
  parameter int         NUM_REGS = 16,
  parameter logic [7:0] TXD_IDLE = 8'hC3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [7:0]  rxd_data,
  input  logic        rxd_flag,
  output logic [7:0]  txd_data,
  output logic        busy,
  output logic [7:0]  err_cnt,
  spi_reg_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR,
    RD_ISSUE,
    RD_CAP,
    RD_WAIT,
    DISCARD
  } state_t;

  localparam logic [7:0]    NUM_REGS_B = 8'(NUM_REGS);
  localparam logic [AW-1:0] LAST_ADDR  = AW'(NUM_REGS - 1);

  state_t        state_q, state_d;
  logic          cs_meta_q, cs_s_q;
  logic          flag_q;
  logic          byte_evt;
  logic [7:0]    txd_q, txd_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic [7:0]    err_q, err_d;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + AW'(1);
  endfunction

  assign byte_evt = rxd_flag & ~flag_q;

  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    addr_d  = addr_q;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    err_d   = err_q;

    // Address advances the clock after a write strobe, even if the frame is closing.
    if (wr_q) begin
      addr_d = next_addr(addr_q);
    end

    if (cs_s_q) begin
      state_d = IDLE;
      txd_d   = TXD_IDLE;
    end else begin
      case (state_q)
        IDLE: state_d = CMD;
        CMD: begin
          if (byte_evt) begin
            if ({1'b0, rxd_data[6:0]} >= NUM_REGS_B) begin
              state_d = DISCARD;
              if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
              end
            end else begin
              addr_d = AW'(rxd_data[6:0]);
              if (rxd_data[7]) begin
                state_d = RD_ISSUE;
                rd_d    = 1'b1;
              end else begin
                state_d = WR;
              end
            end
          end
        end
        WR: begin
          if (byte_evt) begin
            wr_d    = 1'b1;
            wdata_d = rxd_data;
          end
        end
        RD_ISSUE: state_d = RD_CAP;
        RD_CAP: begin
          txd_d   = bus.bus_rdata;
          state_d = RD_WAIT;
        end
        RD_WAIT: begin
          // The dummy byte of a pipelined read fetches the next register.
          if (byte_evt) begin
            addr_d  = next_addr(addr_q);
            state_d = RD_ISSUE;
            rd_d    = 1'b1;
          end
        end
        DISCARD: state_d = DISCARD;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_meta_q <= 1'b1;
      cs_s_q    <= 1'b1;
      flag_q    <= 1'b0;
      state_q   <= IDLE;
      txd_q     <= TXD_IDLE;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= 8'h00;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 8'h00;
    end else begin
      cs_meta_q <= cs;
      cs_s_q    <= cs_meta_q;
      flag_q    <= rxd_flag;
      state_q   <= state_d;
      txd_q     <= txd_d;
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign txd_data      = txd_q;
  assign busy          = busy_q;
  assign err_cnt       = err_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_rd    = rd_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: register bus model, strobe logs and immediate-assertion checks.
module tb_spi_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b1;
  logic       rxd_flag = 1'b0;
  logic [7:0] rxd_data = 8'h00;
  logic [7:0] txd_data;
  logic [7:0] err_cnt;
  logic       busy;

  int checks = 0;
  int failures = 0;

  logic [7:0]  regs [16];
  logic [11:0] wr_log [$];
  logic [3:0]  rd_log [$];
  logic        overlap = 1'b0;

  spi_reg_ctrl_if #(.AW(4)) bus ();

  spi_reg_ctrl #(
    .AW(4),
    .NUM_REGS(16),
    .TXD_IDLE(8'hC3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cs(cs),
    .rxd_data(rxd_data),
    .rxd_flag(rxd_flag),
    .txd_data(txd_data),
    .busy(busy),
    .err_cnt(err_cnt),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  // User register model: read data returned one clock after bus_rd.
  always @(posedge clk) begin
    if (bus.bus_rd) bus.bus_rdata <= regs[bus.bus_addr];
    if (bus.bus_wr) regs[bus.bus_addr] <= bus.bus_wdata;
  end

  always @(negedge clk) begin
    if (bus.bus_wr) wr_log.push_back({bus.bus_addr, bus.bus_wdata});
    if (bus.bus_rd) rd_log.push_back(bus.bus_addr);
    if (bus.bus_wr && bus.bus_rd) overlap = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd_data = b;
    rxd_flag = 1'b1;
    ticks(2);
    rxd_flag = 1'b0;
    ticks(6);
  endtask

  task automatic frame_start();
    cs = 1'b0;
    ticks(3);
  endtask

  task automatic frame_end();
    cs = 1'b1;
    ticks(3);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    regs[5] = 8'h11;
    regs[6] = 8'h22;
    regs[7] = 8'h33;

    // Reset release with cs idle
    ticks(3);
    rst = 1'b1;
    ticks(4);
    chk("rst_txd",  32'(txd_data), 32'h0C3);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err",  32'(err_cnt), 32'h0);
    chk("rst_strb", 32'({bus.bus_wr, bus.bus_rd, bus.bus_addr}), 32'h0);

    // Write frame 0x02, 0xAA, 0x55
    frame_start();
    chk("wr_busy", 32'(busy), 32'h1);
    send_byte(8'h02);
    rxd_data = 8'hAA;
    rxd_flag = 1'b1;
    tick();
    chk("wr_lat1", 32'({bus.bus_wr, bus.bus_addr, bus.bus_wdata}), 32'h12AA);
    tick();
    rxd_flag = 1'b0;
    ticks(6);
    send_byte(8'h55);
    frame_end();
    chk("busy_fall", 32'(busy), 32'h0);
    chk("wr_cnt", 32'(wr_log.size()), 32'd2);
    chk("wr_seq", 32'({wr_log[0], wr_log[1]}), 32'h2AA355);

    // Pipelined read from 5
    frame_start();
    rxd_data = 8'h85;
    rxd_flag = 1'b1;
    tick();
    chk("rd_strobe", 32'({bus.bus_rd, bus.bus_addr}), 32'h15);
    tick();
    chk("rd_lat2", 32'(txd_data), 32'h0C3);
    tick();
    chk("rd_lat3", 32'(txd_data), 32'h011);
    rxd_flag = 1'b0;
    ticks(5);
    send_byte(8'h00);
    chk("rd_txd6", 32'(txd_data), 32'h022);
    send_byte(8'h00);
    chk("rd_txd7", 32'(txd_data), 32'h033);
    frame_end();
    chk("rd_idle_txd", 32'(txd_data), 32'h0C3);
    chk("rd_addrs", 32'({rd_log.size() == 3, rd_log[0], rd_log[1], rd_log[2]}), 32'h1567);

    // Address wrap from 15
    frame_start();
    send_byte(8'h0F);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC4);
    frame_end();
    chk("wrap_cnt", 32'(wr_log.size()), 32'd5);
    chk("wrap_seq", 32'({wr_log[2][11:8], wr_log[3][11:8], wr_log[4][11:8]}), 32'hF01);
    chk("wrap_dat", 32'({wr_log[2][7:0], wr_log[3][7:0], wr_log[4][7:0]}), 32'hA1B2C4);

    // Rejected command
    frame_start();
    send_byte(8'h20);
    chk("disc_busy", 32'(busy), 32'h1);
    send_byte(8'h11);
    send_byte(8'h22);
    frame_end();
    chk("err_one", 32'(err_cnt), 32'h1);
    chk("disc_nostrb", 32'({wr_log.size() == 5, rd_log.size() == 3}), 32'h3);

    // First out-of-range address, repeated up to saturation
    for (int i = 0; i < 253; i++) begin
      frame_start();
      send_byte(8'h10);
      frame_end();
    end
    chk("err_fe", 32'(err_cnt), 32'h0FE);
    for (int i = 0; i < 46; i++) begin
      frame_start();
      send_byte(8'h90);
      frame_end();
    end
    chk("err_sat", 32'(err_cnt), 32'h0FF);

    // Byte edge coinciding with synchronised cs rise is dropped
    frame_start();
    send_byte(8'h04);
    send_byte(8'h66);
    cs = 1'b1;
    ticks(2);
    rxd_data = 8'h77;
    rxd_flag = 1'b1;
    tick();
    chk("abort_idle", 32'({bus.bus_wr, busy}), 32'h0);
    tick();
    rxd_flag = 1'b0;
    ticks(6);
    chk("abort_log", 32'({wr_log.size() == 6, wr_log[5]}), 32'h1466);
    chk("abort_reg4", 32'(regs[4]), 32'h066);

    // Asynchronous reset in the middle of a read frame
    frame_start();
    rxd_data = 8'h85;
    rxd_flag = 1'b1;
    ticks(3);
    rxd_flag = 1'b0;
    chk("pre_rst", 32'({busy, txd_data}), 32'h111);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_txd", 32'(txd_data), 32'h0C3);
    chk("arst_busy_err", 32'({busy, err_cnt}), 32'h0);
    chk("arst_bus", 32'({bus.bus_wr, bus.bus_rd, bus.bus_addr, bus.bus_wdata}), 32'h0);
    cs = 1'b1;
    ticks(2);
    rst = 1'b1;
    ticks(4);
    chk("no_overlap", 32'(overlap), 32'h0);
    chk("rd_total", 32'(rd_log.size()), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
